// File: rtl/gc_ref_mem_bank.sv
// Gain-cell DRAM bank with write-first user port, refresh-chain target/source
// engines and a saturating retention timer that raises ref_req.
module gc_ref_mem_bank #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 128,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int RET_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              u_we,
    input  logic [ADDR_W-1:0] u_write_addr,
    input  logic [DATA_W-1:0] u_data_in,
    input  logic              u_re,
    input  logic [ADDR_W-1:0] u_read_addr,
    output logic [DATA_W-1:0] rd,
    output logic              rd_valid,
    input  logic              ref_in_valid,
    input  logic [ADDR_W-1:0] ref_in_addr,
    input  logic [DATA_W-1:0] ref_in_data,
    output logic              ref_done,
    input  logic              start_sr,
    output logic              ref_out_valid,
    output logic [ADDR_W-1:0] ref_out_addr,
    output logic [DATA_W-1:0] ref_out_data,
    output logic              src_done,
    output logic              ref_req
);

    localparam int                CNT_W     = $clog2(RET_CYCLES + 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  RET_LIM   = CNT_W'(RET_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} src_state_e;

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    logic              u_wr_ok;
    logic              ref_wr_ok;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              rd_valid_q;
    logic              ref_done_q, ref_done_d;
    src_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ref_out_valid_q, ref_out_valid_d;
    logic [ADDR_W-1:0] ref_out_addr_q, ref_out_addr_d;
    logic [DATA_W-1:0] ref_out_data_q, ref_out_data_d;
    logic              src_done_q, src_done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // A ref_in beat colliding with a user write to the same row is dropped.
    assign u_wr_ok   = u_we && ({1'b0, u_write_addr} < DEPTH_EXT);
    assign ref_wr_ok = ref_in_valid && ({1'b0, ref_in_addr} < DEPTH_EXT)
                       && !(u_wr_ok && (u_write_addr == ref_in_addr));

    // Write-first view of one row: user write, then ref_in write, then array.
    function automatic logic [DATA_W-1:0] fwd_row(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              uw,
        input logic [ADDR_W-1:0] ua,
        input logic [DATA_W-1:0] ud,
        input logic              rw,
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] rdat
    );
        if ({1'b0, addr} >= DEPTH_EXT) return '0;
        if (uw && (ua == addr))        return ud;
        if (rw && (ra == addr))        return rdat;
        return stored;
    endfunction

    always_ff @(posedge clk) begin
        if (u_wr_ok) begin
            mem_q[u_write_addr] <= u_data_in;
        end
        if (ref_wr_ok) begin
            mem_q[ref_in_addr] <= ref_in_data;
        end
    end

    always_comb begin
        rd_d = rd_q;
        if (u_re) begin
            rd_d = fwd_row(u_read_addr, mem_q[u_read_addr], u_wr_ok, u_write_addr,
                           u_data_in, ref_wr_ok, ref_in_addr, ref_in_data);
        end
    end

    assign ref_done_d = ref_in_valid && (ref_in_addr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            ref_done_q <= 1'b0;
        end else begin
            rd_q       <= rd_d;
            rd_valid_q <= u_re;
            ref_done_q <= ref_done_d;
        end
    end

    // Source FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Source FSM: next state; ptr never advances past the last row
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (start_sr) begin
                    state_d = S_STREAM;
                    ptr_d   = '0;
                end
            end
            S_STREAM: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Source FSM: outputs, registered one cycle behind the state
    always_comb begin
        ref_out_valid_d = 1'b0;
        ref_out_addr_d  = ref_out_addr_q;
        ref_out_data_d  = ref_out_data_q;
        src_done_d      = 1'b0;
        case (state_q)
            S_STREAM: begin
                ref_out_valid_d = 1'b1;
                ref_out_addr_d  = ptr_q;
                ref_out_data_d  = fwd_row(ptr_q, mem_q[ptr_q], u_wr_ok, u_write_addr,
                                          u_data_in, ref_wr_ok, ref_in_addr, ref_in_data);
            end
            S_DONE:  src_done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_out_valid_q <= 1'b0;
            ref_out_addr_q  <= '0;
            ref_out_data_q  <= '0;
            src_done_q      <= 1'b0;
        end else begin
            ref_out_valid_q <= ref_out_valid_d;
            ref_out_addr_q  <= ref_out_addr_d;
            ref_out_data_q  <= ref_out_data_d;
            src_done_q      <= src_done_d;
        end
    end

    // Retention age: clear on ref_done beats saturation
    always_comb begin
        if (ref_done_q) begin
            cnt_d = '0;
        end else if (cnt_q == RET_LIM) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rd            = rd_q;
    assign rd_valid      = rd_valid_q;
    assign ref_done      = ref_done_q;
    assign ref_out_valid = ref_out_valid_q;
    assign ref_out_addr  = ref_out_addr_q;
    assign ref_out_data  = ref_out_data_q;
    assign src_done      = src_done_q;
    assign ref_req       = (cnt_q == RET_LIM);

endmodule

// File: tb/tb_gc_ref_mem_bank.sv
// Directed bench for gc_ref_mem_bank (128x64, 16-cycle retention budget).
module tb_gc_ref_mem_bank;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;
    localparam int RET    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              u_we;
    logic [ADDR_W-1:0] u_write_addr;
    logic [DATA_W-1:0] u_data_in;
    logic              u_re;
    logic [ADDR_W-1:0] u_read_addr;
    logic [DATA_W-1:0] rd;
    logic              rd_valid;
    logic              ref_in_valid;
    logic [ADDR_W-1:0] ref_in_addr;
    logic [DATA_W-1:0] ref_in_data;
    logic              ref_done;
    logic              start_sr;
    logic              ref_out_valid;
    logic [ADDR_W-1:0] ref_out_addr;
    logic [DATA_W-1:0] ref_out_data;
    logic              src_done;
    logic              ref_req;

    int n_cmp = 0;
    int n_bad = 0;

    gc_ref_mem_bank #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .RET_CYCLES (RET)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .u_we          (u_we),
        .u_write_addr  (u_write_addr),
        .u_data_in     (u_data_in),
        .u_re          (u_re),
        .u_read_addr   (u_read_addr),
        .rd            (rd),
        .rd_valid      (rd_valid),
        .ref_in_valid  (ref_in_valid),
        .ref_in_addr   (ref_in_addr),
        .ref_in_data   (ref_in_data),
        .ref_done      (ref_done),
        .start_sr      (start_sr),
        .ref_out_valid (ref_out_valid),
        .ref_out_addr  (ref_out_addr),
        .ref_out_data  (ref_out_data),
        .src_done      (src_done),
        .ref_req       (ref_req)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] src_exp(input int k);
        return (k == 5) ? 64'hDEAD : 64'h100 + 64'(k);
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; u_we = 1'b0; u_write_addr = '0; u_data_in = '0;
        u_re = 1'b0; u_read_addr = '0; ref_in_valid = 1'b0; ref_in_addr = '0;
        ref_in_data = '0; start_sr = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_rd", rd, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_ref_done", ref_done, 0);
        chk("rst_out_valid", ref_out_valid, 0);
        chk("rst_out_addr", ref_out_addr, 0);
        chk("rst_out_data", ref_out_data, 0);
        chk("rst_src_done", src_done, 0);
        chk("rst_ref_req", ref_req, 0);
        $display("reset released");
        rst = 1'b0;

        // Retention ramp: ref_req rises RET edges after the last reset edge
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("ret_ramp", ref_req, k >= RET);
        end
        $display("retention ramp observed for 20 cycles");

        // Write then read
        u_we = 1'b1; u_write_addr = 7'd10; u_data_in = 64'd9;
        tick();
        $display("write row 10 data 9");
        u_we = 1'b0; u_re = 1'b1; u_read_addr = 7'd10;
        chk("wr_rd_valid_idle", rd_valid, 0);
        tick();
        chk("wr_rd_data", rd, 9);
        chk("wr_rd_valid", rd_valid, 1);
        $display("read row 10 -> %0d", rd);
        u_re = 1'b0;
        tick();
        chk("rd_hold_valid", rd_valid, 0);
        chk("rd_hold_data", rd, 9);

        // Refresh target sweep with data i+1
        for (int i = 0; i < DEPTH; i++) begin
            ref_in_valid = 1'b1; ref_in_addr = 7'(i); ref_in_data = 64'(i + 1);
            tick();
            chk("tgt_ref_done", ref_done, i == DEPTH - 1);
        end
        chk("tgt_req_before_clear", ref_req, 1);
        ref_in_valid = 1'b0;
        tick();
        chk("tgt_done_drop", ref_done, 0);
        chk("tgt_req_cleared", ref_req, 0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk("tgt_ret_restart", ref_req, k >= RET);
        end
        for (int i = 0; i < DEPTH; i++) begin
            u_re = 1'b1; u_read_addr = 7'(i);
            tick();
            chk("tgt_readback", rd, 64'(i + 1));
        end
        u_re = 1'b0;
        $display("refresh target sweep of %0d rows", DEPTH);

        // Collision sweep: user data wins, forwarded to a same-cycle read
        for (int i = 0; i < DEPTH; i++) begin
            ref_in_valid = 1'b1; ref_in_addr = 7'(i); ref_in_data = 64'(i + 1);
            u_we = 1'b1; u_write_addr = 7'(i); u_data_in = 64'(900 + i);
            u_re = 1'b1; u_read_addr = 7'(i);
            tick();
            chk("col_fwd", rd, 64'(900 + i));
        end
        ref_in_valid = 1'b0; u_we = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            u_read_addr = 7'(i);
            tick();
            chk("col_readback", rd, 64'(900 + i));
        end
        u_re = 1'b0;
        $display("collision sweep of %0d rows", DEPTH);

        // ref_in forwarded over array; user write to another row commits too
        ref_in_valid = 1'b1; ref_in_addr = 7'd3; ref_in_data = 64'h777;
        u_we = 1'b1; u_write_addr = 7'd4; u_data_in = 64'h444;
        u_re = 1'b1; u_read_addr = 7'd3;
        tick();
        chk("refin_fwd", rd, 64'h777);
        ref_in_valid = 1'b0; u_we = 1'b0; u_read_addr = 7'd4;
        tick();
        chk("dual_commit_user", rd, 64'h444);
        u_read_addr = 7'd3;
        tick();
        chk("dual_commit_ref", rd, 64'h777);
        u_re = 1'b0;
        $display("dual-port write rows 3/4");

        // Preload 0x100+i, then source sweep with a forwarded write on row 5
        for (int i = 0; i < DEPTH; i++) begin
            u_we = 1'b1; u_write_addr = 7'(i); u_data_in = 64'h100 + 64'(i);
            tick();
        end
        u_we = 1'b0;
        start_sr = 1'b1;
        tick();
        start_sr = 1'b0;
        chk("src_first_idle", ref_out_valid, 0);
        for (int k = 0; k < DEPTH; k++) begin
            u_we = (k == 5); u_write_addr = 7'd5; u_data_in = 64'hDEAD;
            start_sr = (k == 50);
            tick();
            chk("src_valid", ref_out_valid, 1);
            chk("src_addr", ref_out_addr, 64'(k));
            chk("src_data", ref_out_data, src_exp(k));
            chk("src_done_early", src_done, 0);
        end
        u_we = 1'b0; start_sr = 1'b0;
        tick();
        chk("src_done_pulse", src_done, 1);
        chk("src_valid_drop", ref_out_valid, 0);
        tick();
        chk("src_done_once", src_done, 0);
        $display("source sweep of %0d rows", DEPTH);

        // Reset mid-stream at row 40
        start_sr = 1'b1;
        tick();
        start_sr = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            tick();
            chk("mid_addr", ref_out_addr, 64'(k));
        end
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", ref_out_valid, 0);
        chk("mid_rst_addr", ref_out_addr, 0);
        chk("mid_rst_data", ref_out_data, 0);
        chk("mid_rst_src_done", src_done, 0);
        chk("mid_rst_rd", rd, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_ref_done", ref_done, 0);
        chk("mid_rst_ref_req", ref_req, 0);
        rst = 1'b0;
        for (int k = 0; k < 140; k++) begin
            tick();
            chk("mid_no_src_done", src_done, 0);
            chk("mid_no_valid", ref_out_valid, 0);
        end
        start_sr = 1'b1;
        tick();
        start_sr = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            chk("restart_addr", ref_out_addr, 64'(k));
            chk("restart_data", ref_out_data, src_exp(k));
        end
        tick();
        chk("restart_src_done", src_done, 1);
        $display("reset mid-stream and restarted sweep");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gc_ref_mem_bank.md
# gc_ref_mem_bank

Parametrised gain-cell DRAM bank with a built-in refresh-chain engine. It is the generalised successor of the fixed 128x64 memory wrapper. Each bank can act as refresh target, absorbing a row stream from the previous bank, and as refresh source, streaming its own rows to the next bank. User reads and writes proceed throughout, with user writes given fixed priority. A per-bank retention timer raises a refresh request when data age reaches `RET_CYCLES`.

## Interface
- `DATA_W`, 64: row width in bits
- `DEPTH`, 128: number of rows (≥2)
- `ADDR_W`, `$clog2(DEPTH)`: address width
- `RET_CYCLES`, 1024: retention budget in cycles (≥1)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `u_we` in 1: user write enable
- `u_write_addr` in ADDR_W: user write row
- `u_data_in` in DATA_W: user write data
- `u_re` in 1: user read enable
- `u_read_addr` in ADDR_W: user read row
- `rd` out DATA_W: registered read data
- `rd_valid` out 1: `rd` valid, 1 cycle after `u_re`
- `ref_in_valid` in 1: incoming refresh row valid
- `ref_in_addr` in ADDR_W: incoming refresh row address
- `ref_in_data` in DATA_W: incoming refresh row data
- `ref_done` out 1: 1-cycle pulse after row DEPTH-1 is accepted from `ref_in`
- `start_sr` in 1: 1-cycle pulse, begin sourcing all rows
- `ref_out_valid` out 1: outgoing refresh row valid
- `ref_out_addr` out ADDR_W: outgoing row address
- `ref_out_data` out DATA_W: outgoing row data
- `src_done` out 1: 1-cycle pulse after last row is sourced
- `ref_req` out 1: retention budget exhausted

## Operation
- The array is DEPTH x DATA_W. It is not reset, so contents are undefined until written.
- **Write arbitration, per cycle:**
  - User write to row A and `ref_in_valid` to row A in the same cycle: user data is stored and the ref row is dropped.
  - Writes to different rows both commit.
- **Read:** `rd` is registered. Read and write to the same row in the same cycle returns the newly written value (write-first), using the same priority: user > ref_in > array.
- `rd` holds its last value when `u_re`=0, and `rd_valid`=0.
- **Target side:** `ref_done` pulses the cycle after a `ref_in_valid` beat with `ref_in_addr`=DEPTH-1, even if that row was overridden by a user write. Addresses are not checked for order.
- **Source FSM:** states are IDLE, STREAM, DONE.
  - IDLE → STREAM on `start_sr`. The row pointer `ptr` is cleared to 0.
  - In STREAM, row `ptr` is read each cycle and presented registered on the next cycle. `ptr` increments.
  - STREAM → DONE after `ptr`=DEPTH-1 is read.
  - DONE → IDLE unconditionally. `src_done`=1 while in DONE.
  - `start_sr` outside IDLE is ignored.
- **Source forwarding:** if a write (user or ref_in, with priority) hits row `ptr` in the cycle it is read, `ref_out_data` carries the written value.
- **Retention counter:**
  - Increments each cycle and saturates at RET_CYCLES.
  - `ref_req` = (count == RET_CYCLES).
  - The counter clears to 0 in the cycle `ref_done` is asserted.
  - `start_sr` does not clear it.
- **Width rules:** the address counter wraps modulo 2^ADDR_W but is never advanced past DEPTH-1. Out-of-range addresses (≥DEPTH, when DEPTH is not a power of 2) are ignored for writes and return 0 for reads.

## Timing
- **Reset values:** `rd`=0, `rd_valid`=0, `ref_done`=0, `ref_out_valid`=0, `ref_out_addr`=0, `ref_out_data`=0, `src_done`=0, `ref_req`=0. The FSM is in IDLE and the retention counter is 0.
- **Read latency:** `u_re` at edge N gives `rd`/`rd_valid` at N+1. Back-to-back reads give one result per cycle.
- **Write latency:** a write at edge N is visible to a read issued at N (forwarded) and to all later reads.
- **Source stream:**
  - `start_sr` at edge N gives `ref_out_valid`=1 with addr 0 at N+1 through addr DEPTH-1 at N+DEPTH.
  - `src_done` pulses at N+DEPTH+1, with `ref_out_valid`=0 at that edge.
- **Target pulse:** `ref_done` is 1 exactly one cycle after the final-row beat.
- **Retention:** `ref_req` rises RET_CYCLES cycles after reset or after the last `ref_done`. `ref_done` and saturation in the same cycle: clear wins.
- **Reset mid-stream:** the FSM aborts to IDLE, all outputs drop to reset values on the next edge, and no `src_done` is issued. Array contents are kept.

## Test plan
- **Write then read:** write 9 to row 10, then read row 10 next cycle → `rd`=9 with `rd_valid`=1, 1 cycle after `u_re`.
- **Refresh target:** stream `ref_in` rows 0..127 with data i+1 → `ref_done` pulses once, the cycle after row 127. Reading all rows returns i+1, and the retention counter restarts from 0.
- **Write collision:** during a ref_in sweep (data i+1), user writes 900+i to row i in the same cycle → reads of every row return 900+i.
- **Refresh source with forwarding:** preload rows with 0x100+i, pulse `start_sr`, and write 0xDEAD to row 5 in the cycle it is read → `ref_out` shows addr 0..127 on 128 consecutive cycles, row 5 = 0xDEAD, others 0x100+i, then `src_done` one cycle later.
- **Retention timer:** with RET_CYCLES=16, after reset `ref_req` rises at cycle 16 and stays high. A completed ref_in sweep drops it the cycle after `ref_done`.
- **Reset mid-stream:** assert `rst` at row 40 of a source sweep → outputs go to 0 and no `src_done` occurs. A later `start_sr` restarts from addr 0 with array data intact.
